// File: rtl/elevator_scan.sv
// SCAN-order elevator controller: latches floor calls, sweeps in one direction
// serving every pending floor on the way, and reverses only when idle.
module elevator_scan #(
  parameter int unsigned N_FLOORS      = 8,
  parameter int unsigned TRAVEL_CYCLES = 10,
  parameter int unsigned DOOR_CYCLES   = 5,
  localparam int unsigned FW = (N_FLOORS > 2) ? $clog2(N_FLOORS) : 1
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [N_FLOORS-1:0] i_requests,
  output logic [FW-1:0]       o_current_floor,
  output logic                o_moving,
  output logic                o_dir_up,
  output logic                o_door_open,
  output logic [N_FLOORS-1:0] o_pending
);

  localparam int unsigned TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [FW-1:0] TOP_FLOOR = FW'(N_FLOORS - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST    = DW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [FW-1:0]       floor_q, floor_d;
  logic                dir_q, dir_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic                moving_q, door_q;

  logic [N_FLOORS-1:0] clear_mask;
  logic [N_FLOORS-1:0] req_eff;
  logic [N_FLOORS-1:0] calls_now;
  logic [FW-1:0]       step_floor;

  // True when any call lies strictly beyond fl in the given direction
  function automatic logic call_ahead(input logic [N_FLOORS-1:0] calls,
                                      input logic [FW-1:0] fl,
                                      input logic up);
    logic hit;
    hit = 1'b0;
    for (int f = 0; f < int'(N_FLOORS); f++) begin
      if (calls[f] && (up ? (f > int'(fl)) : (f < int'(fl)))) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    step_floor = floor_q;
    if (dir_q && (floor_q != TOP_FLOOR)) begin
      step_floor = floor_q + FW'(1);
    end else if (!dir_q && (floor_q != '0)) begin
      step_floor = floor_q - FW'(1);
    end
  end

  assign calls_now = pending_q | i_requests;

  // Next-state, counters and pending update
  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    tcnt_d     = tcnt_q;
    dcnt_d     = dcnt_q;
    clear_mask = '0;
    req_eff    = i_requests;

    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        dcnt_d = '0;
        if (pending_q[floor_q]) begin
          state_d    = DOOR;
          clear_mask = N_FLOORS'(1) << floor_q;
        end else if (call_ahead(pending_q, floor_q, dir_q)) begin
          state_d = MOVE;
        end else if (call_ahead(pending_q, floor_q, !dir_q)) begin
          dir_d   = !dir_q;
          state_d = MOVE;
        end
      end

      MOVE: begin
        dcnt_d = '0;
        if (tcnt_q == T_LAST) begin
          tcnt_d  = '0;
          floor_d = step_floor;
          if (calls_now[step_floor]) begin
            state_d    = DOOR;
            clear_mask = N_FLOORS'(1) << step_floor;
          end else if (!call_ahead(calls_now, step_floor, dir_q)) begin
            state_d = IDLE;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      DOOR: begin
        // A call for the floor being served only extends the dwell
        req_eff = i_requests & ~(N_FLOORS'(1) << floor_q);
        if (i_requests[floor_q]) begin
          dcnt_d = '0;
        end else if (dcnt_q == D_LAST) begin
          dcnt_d  = '0;
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    pending_d = (pending_q | req_eff) & ~clear_mask;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      pending_q <= '0;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
      moving_q  <= 1'b0;
      door_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      tcnt_q    <= tcnt_d;
      dcnt_q    <= dcnt_d;
      moving_q  <= (state_d == MOVE);
      door_q    <= (state_d == DOOR);
    end
  end

  assign o_current_floor = floor_q;
  assign o_moving        = moving_q;
  assign o_dir_up        = dir_q;
  assign o_door_open     = door_q;
  assign o_pending       = pending_q;

endmodule

// File: tb/tb_elevator_scan.sv
// Self-checking bench for elevator_scan: directed scenarios plus random calls,
// all compared every cycle against a countdown-based behavioural model.
module tb_elevator_scan;

  localparam int unsigned NF = 8;
  localparam int unsigned TC = 10;
  localparam int unsigned DC = 5;

  logic          clk;
  logic          rst;
  logic [NF-1:0] i_requests;
  logic [2:0]    o_current_floor;
  logic          o_moving;
  logic          o_dir_up;
  logic          o_door_open;
  logic [NF-1:0] o_pending;

  int n_tests = 0;
  int n_fail  = 0;

  elevator_scan #(
    .N_FLOORS(NF),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES(DC)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_requests(i_requests),
    .o_current_floor(o_current_floor),
    .o_moving(o_moving),
    .o_dir_up(o_dir_up),
    .o_door_open(o_door_open),
    .o_pending(o_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: 0 idle, 1 travelling, 2 door open; m_left counts down
  int          m_floor;
  bit          m_up;
  int          m_mode;
  int          m_left;
  bit [NF-1:0] m_pend;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit any_dir(input bit [NF-1:0] p, input int fl, input bit up);
    for (int f = 0; f < int'(NF); f++) begin
      if (p[f] && (up ? (f > fl) : (f < fl))) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_floor = 0;
    m_up    = 1'b1;
    m_mode  = 0;
    m_left  = 0;
    m_pend  = '0;
  endtask

  task automatic model_step(input bit [NF-1:0] req);
    bit [NF-1:0] old;
    bit [NF-1:0] here;
    old  = m_pend;
    here = '0;
    here[m_floor] = 1'b1;
    case (m_mode)
      0: begin
        m_pend = old | req;
        if (old[m_floor]) begin
          m_pend[m_floor] = 1'b0;
          m_mode = 2;
          m_left = DC;
        end else if (any_dir(old, m_floor, m_up)) begin
          m_mode = 1;
          m_left = TC;
        end else if (any_dir(old, m_floor, !m_up)) begin
          m_up   = !m_up;
          m_mode = 1;
          m_left = TC;
        end
      end
      1: begin
        m_pend = old | req;
        m_left--;
        if (m_left == 0) begin
          m_floor += m_up ? 1 : -1;
          if (m_pend[m_floor]) begin
            m_pend[m_floor] = 1'b0;
            m_mode = 2;
            m_left = DC;
          end else if (any_dir(m_pend, m_floor, m_up)) begin
            m_left = TC;
          end else begin
            m_mode = 0;
          end
        end
      end
      default: begin
        m_pend = old | (req & ~here);
        if (req[m_floor]) m_left = DC;
        else m_left--;
        if (m_left == 0) m_mode = 0;
      end
    endcase
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_floor"},   32'(o_current_floor), 32'(m_floor));
    check({tag, "_moving"},  32'(o_moving),        32'(m_mode == 1));
    check({tag, "_dir"},     32'(o_dir_up),        32'(m_up));
    check({tag, "_door"},    32'(o_door_open),     32'(m_mode == 2));
    check({tag, "_pending"}, 32'(o_pending),       32'(m_pend));
  endtask

  task automatic step(input logic [NF-1:0] req);
    i_requests = req;
    @(posedge clk);
    model_step(req);
    #1;
    i_requests = '0;
    compare_all("cyc");
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst");
    check("rst_floor0", 32'(o_current_floor), 0);
    check("rst_pend0",  32'(o_pending), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Steps with no calls until the door opens; n = edges taken
  task automatic wait_door(input int max_cyc, output int n);
    bit prev;
    n = 0;
    prev = o_door_open;
    for (int i = 0; i < max_cyc; i++) begin
      step('0);
      n++;
      if (o_door_open && !prev) return;
      prev = o_door_open;
    end
    check("door_timeout", 0, 1);
  endtask

  task automatic run_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (m_mode == 0 && m_pend == '0) return;
      step('0);
    end
    check("idle_timeout", 0, 1);
  endtask

  int n, n2, cnt;
  int served[$];
  int mv_dirs[$];
  bit prev_door, prev_mov;
  logic [NF-1:0] rreq;

  initial begin
    rst = 1'b0;
    i_requests = '0;
    model_reset();

    // Reset values
    do_reset();
    compare_all("post_rst");

    // Single call to floor 3 from floor 0
    step(NF'(8'h08));
    check("s2_not_yet_moving", 32'(o_moving), 0);
    step('0);
    check("s2_moving_k1", 32'(o_moving), 1);
    wait_door(100, n);
    check("s2_door_latency", 32'(n + 1), 31);
    check("s2_door_floor", 32'(o_current_floor), 3);
    cnt = 1;
    for (int i = 0; i < 20 && o_door_open; i++) begin
      step('0);
      if (o_door_open) cnt++;
    end
    check("s2_door_len", 32'(cnt), DC);
    check("s2_pend3_clr", 32'(o_pending[3]), 0);
    check("s2_idle", 32'(o_moving), 0);

    // Calls 2 and 5 together from floor 0
    do_reset();
    step(NF'(8'h24));
    wait_door(100, n);
    check("s3_first_lat", 32'(n), 21);
    check("s3_first_floor", 32'(o_current_floor), 2);
    wait_door(100, n2);
    check("s3_second_lat", 32'(n + n2), 57);
    check("s3_second_floor", 32'(o_current_floor), 5);
    run_idle(50);

    // SCAN: moving 2 -> 6, calls 1 and 4 injected en route
    do_reset();
    step(NF'(8'h04));
    wait_door(100, n);
    run_idle(50);
    step(NF'(8'h40));
    for (int i = 0; i < 5; i++) step('0);
    step(NF'(8'h12));
    served.delete();
    mv_dirs.delete();
    prev_door = o_door_open;
    prev_mov  = o_moving;
    for (int i = 0; i < 400 && !(m_mode == 0 && m_pend == '0); i++) begin
      step('0);
      if (o_door_open && !prev_door) served.push_back(int'(o_current_floor));
      if (o_moving && !prev_mov) mv_dirs.push_back(int'(o_dir_up));
      prev_door = o_door_open;
      prev_mov  = o_moving;
    end
    check("s4_n_served", 32'(served.size()), 3);
    if (served.size() == 3) begin
      check("s4_serve0", 32'(served[0]), 4);
      check("s4_serve1", 32'(served[1]), 6);
      check("s4_serve2", 32'(served[2]), 1);
    end
    check("s4_n_departs", 32'(mv_dirs.size()), 2);
    if (mv_dirs.size() == 2) begin
      check("s4_dir_after4", 32'(mv_dirs[0]), 1);
      check("s4_dir_after6", 32'(mv_dirs[1]), 0);
    end

    // Repeated call for the open-door floor extends the dwell
    do_reset();
    step(NF'(8'h10));
    wait_door(100, n);
    step('0);
    step(NF'(8'h10));
    step('0);
    step(NF'(8'h10));
    check("s5_pend4_unset", 32'(o_pending[4]), 0);
    cnt = 1;
    for (int i = 0; i < 20 && o_door_open; i++) begin
      step('0);
      if (o_door_open) cnt++;
    end
    check("s5_dwell_after_pulse", 32'(cnt), DC);
    check("s5_pend4_after", 32'(o_pending[4]), 0);

    // Reset mid-travel between floors 3 and 4 with call 6 outstanding
    do_reset();
    step(NF'(8'h40));
    for (int i = 0; i < 100 && o_current_floor != 3'd3; i++) step('0);
    for (int i = 0; i < 4; i++) step('0);
    check("s6_mid_move", 32'(o_moving), 1);
    do_reset();
    step(NF'(8'h04));
    wait_door(100, n);
    check("s6_after_rst_lat", 32'(n), 21);
    check("s6_after_rst_floor", 32'(o_current_floor), 2);
    run_idle(50);

    // Top floor, heading up, call for floor 0
    do_reset();
    step(NF'(8'h80));
    wait_door(200, n);
    run_idle(50);
    check("s7_at_top", 32'(o_current_floor), 7);
    check("s7_dir_up", 32'(o_dir_up), 1);
    step(NF'(8'h01));
    step('0);
    check("s7_dir_down", 32'(o_dir_up), 0);
    check("s7_moving", 32'(o_moving), 1);
    wait_door(200, n);
    check("s7_arrive0", 32'(o_current_floor), 0);
    check("s7_lat", 32'(n + 1), 71);
    run_idle(50);

    // Random traffic with occasional mid-operation resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rreq = ($urandom_range(0, 5) == 0) ? NF'($urandom) : '0;
      if ($urandom_range(0, 599) == 0) do_reset();
      else step(rreq);
    end
    run_idle(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
